// File: rtl/rep_word_unpacker.sv
// rtl/rep_word_unpacker.sv - 2-entry skid buffer that unpacks {a,b,b,c} words and counts b-copy mismatches
module rep_word_unpacker #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_a,
  output logic [1:0]           out_b,
  output logic [1:0]           out_c,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Entry layout: {err, a, b[1:0], c[1:0]}
  state_t         state_q, state_d;
  logic [5:0]     main_q, main_d;
  logic [5:0]     skid_q, skid_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic           err_sticky_q, err_sticky_d;

  logic           in_xfer;
  logic           out_xfer;
  logic           consume_err;
  logic [5:0]     dec;

  // Handshake flags come straight from the registered state, so in_ready never depends on out_ready
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign consume_err = out_xfer & main_q[5];

  // Decoded entry; only ever captured on an input transfer, so X on an idle bus never lands in state
  assign dec = {(in_word[5:4] != in_word[3:2]), in_word[6], in_word[5:4], in_word[1:0]};

  assign out_err    = main_q[5];
  assign out_a      = main_q[4];
  assign out_b      = main_q[3:2];
  assign out_c      = main_q[1:0];
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

  // Buffer next-state: main always holds the oldest word, skid only fills when main is stalled
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = dec;
        end else if (in_xfer) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Error accounting: clear wins, except a mismatch consumed in the same cycle still counts once
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_count_d  = consume_err ? ERR_CNT_W'(1) : '0;
      err_sticky_d = consume_err;
    end else if (consume_err) begin
      err_sticky_d = 1'b1;
      if (err_count_q != {ERR_CNT_W{1'b1}}) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule

// File: doc/rep_word_unpacker.md
Name: rep_word_unpacker

Overview:
- Downstream consumer of the 7-bit replicated word produced by the replication packing stage.
- Word layout: bit6 = a; bits[5:4] = b copy 1; bits[3:2] = b copy 2; bits[1:0] = c.
- The block accepts words over a valid/ready handshake and buffers them in a 2-entry skid register.
- It splits each word back into a, b and c, checks that the two b copies agree, and keeps a saturating error count plus a sticky error flag.

Parameters:
ERR_CNT_W, 8, width of the mismatch counter (1..16).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  upstream word valid.
in_ready  output  1  block can accept a word this cycle.
in_word  input  7  packed word {a, b, b, c}.
out_valid  output  1  unpacked word valid.
out_ready  input  1  downstream accepts the word.
out_a  output  1  field a (in_word[6]).
out_b  output  2  field b, taken from the upper copy (in_word[5:4]).
out_c  output  2  field c (in_word[1:0]).
out_err  output  1  set when in_word[5:4] != in_word[3:2] for the word currently presented.
err_count  output  ERR_CNT_W  number of mismatched words consumed, saturating.
err_sticky  output  1  set by any consumed mismatched word; held until cleared.
clr_err  input  1  synchronous clear of err_count and err_sticky.

Behaviour:
- One clock domain. Reset is synchronous and active-low: all state updates only on a clk rising edge with rst_n=0.
- Reset values:
  - in_ready=1, out_valid=0.
  - out_a=0, out_b=0, out_c=0, out_err=0.
  - err_count=0, err_sticky=0.
  - Buffer state EMPTY.
- Input transfer: in_valid && in_ready at a clk edge.
- Output transfer: out_valid && out_ready at a clk edge.
- Decoding is done at input transfer. out_err, out_a, out_b and out_c are stored together as one entry.
- Storage: main register (drives the outputs) plus one skid register.
- States:
  - EMPTY: in_ready=1, out_valid=0. On an input transfer -> ONE, with the new word in main.
  - ONE: in_ready=1, out_valid=1.
    - Input only -> FULL (new word into skid).
    - Output only -> EMPTY.
    - Input and output together -> ONE, with main loaded directly from the new word.
  - FULL: in_ready=0, out_valid=1.
    - Output transfer -> ONE, skid moved into main.
    - Input is ignored while in_ready=0.
- in_ready is registered, driven from state only; there is no combinational path from out_ready.
- Latency: word accepted at edge N is presented on the outputs after edge N when the buffer was EMPTY.
- Ordering is strict FIFO. No word is lost or duplicated under any valid/ready pattern.
- Outputs stay stable while out_valid=1 and out_ready=0.
- Error accounting happens on output transfer of an entry with out_err=1:
  - err_count increments and saturates at 2^ERR_CNT_W-1 (no wrap).
  - err_sticky is set to 1.
- clr_err=1 takes priority: err_count=0 and err_sticky=0.
  - Exception: if a mismatched word is also consumed that same cycle, the result is err_count=1 and err_sticky=1.
- Reset mid-operation:
  - Buffered words are discarded; state returns to EMPTY.
  - A handshake in the reset cycle has no effect.
  - Counters clear.
- X on in_word while in_valid=0 must not propagate to any output or counter.

Test Plan:
- Reset, then in_word=7'b1_01_01_11 with out_ready=1 -> next cycle out_valid=1, out_a=1, out_b=2'b01, out_c=2'b11, out_err=0, err_count=0.
- in_word=7'b0_10_00_00, consumed -> out_a=0, out_b=2'b10, out_c=2'b00, out_err=1; after consumption err_count=1 and err_sticky=1.
- out_ready=0, push words W0=7'h35 and W1=7'h4A -> in_ready=0 after the second accept. Raise out_ready -> W0 then W1 appear in order, in_ready returns to 1 one cycle after W0 leaves.
- ERR_CNT_W=2, stream 5 mismatched words -> err_count reads 1, 2, 3, 3, 3 (saturates, no wrap).
- clr_err=1 in the same cycle a mismatched word is consumed, with err_count=3 -> err_count=1, err_sticky=1. clr_err with no transfer -> err_count=0, err_sticky=0.
- Buffer FULL, assert rst_n=0 for one cycle -> out_valid=0, in_ready=1, err_count=0. The next accepted word is the first one output; no stale data appears.
